// File: rtl/hwpe_stream_tcdm_order_sched_if.sv
// Channel request/grant taps toward the order scheduler and the order/boost
// results it returns to the reorder stage.
interface hwpe_stream_tcdm_order_sched_if #(
  parameter int unsigned NB_CHAN = 4
);
  localparam int unsigned CW = $clog2(NB_CHAN);

  logic [NB_CHAN-1:0] in_req;
  logic [NB_CHAN-1:0] in_gnt;
  logic [CW-1:0]      order;
  logic               boost;
  logic [CW-1:0]      boost_chan;

  modport master (output in_req, in_gnt, input order, boost, boost_chan);
  modport slave  (input in_req, in_gnt, output order, boost, boost_chan);
endinterface

// File: rtl/hwpe_stream_tcdm_order_sched.sv
// Rotation scheduler driving the channel-to-port order of the HWPE-Mem reorder
// stage: fixed, periodic rotation, or adaptive boost of a starving channel.
module hwpe_stream_tcdm_order_sched #(
  parameter int unsigned NB_CHAN  = 4,
  parameter int unsigned PERIOD_W = 8,
  parameter int unsigned STARVE_W = 6,
  localparam int unsigned CW      = $clog2(NB_CHAN)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                enable_i,
  input  logic [1:0]          mode_i,
  input  logic [CW-1:0]       fixed_order_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [STARVE_W-1:0] starve_thr_i,
  hwpe_stream_tcdm_order_sched_if.slave sched
);

  typedef enum logic [1:0] {IDLE, RUN, BOOST} state_t;

  state_t              state;
  logic [CW-1:0]       order_q;
  logic                boost_q;
  logic [CW-1:0]       boost_chan_q;
  logic [PERIOD_W-1:0] period_cnt;
  logic [STARVE_W-1:0] starve_cnt [NB_CHAN];

  logic          starve_hit;
  logic [CW-1:0] starve_sel;
  logic          boost_exit;

  // Lowest-index channel at or above threshold wins ties.
  always_comb begin
    starve_hit = 1'b0;
    starve_sel = '0;
    for (int unsigned c = 0; c < NB_CHAN; c++) begin
      if (!starve_hit && starve_thr_i != '0 && starve_cnt[c] >= starve_thr_i) begin
        starve_hit = 1'b1;
        starve_sel = CW'(c);
      end
    end
  end

  assign boost_exit = sched.in_gnt[boost_chan_q] || !sched.in_req[boost_chan_q]
                      || mode_i != 2'b10;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state        <= IDLE;
      order_q      <= '0;
      boost_q      <= 1'b0;
      boost_chan_q <= '0;
      period_cnt   <= '0;
      for (int unsigned c = 0; c < NB_CHAN; c++) starve_cnt[c] <= '0;
    end else if (state == IDLE) begin
      if (enable_i) state <= RUN;
    end else if (!enable_i) begin
      state      <= IDLE;
      boost_q    <= 1'b0;
      period_cnt <= '0;
      for (int unsigned c = 0; c < NB_CHAN; c++) starve_cnt[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < NB_CHAN; c++) begin
        if (sched.in_gnt[c] || !sched.in_req[c]) starve_cnt[c] <= '0;
        else if (starve_cnt[c] != '1)            starve_cnt[c] <= starve_cnt[c] + STARVE_W'(1);
      end
      if (state == BOOST) begin
        order_q    <= boost_chan_q;
        period_cnt <= '0;
        // Explicit clear covers the mode-change exit, where the channel may still starve.
        if (boost_exit) begin
          state                    <= RUN;
          boost_q                  <= 1'b0;
          starve_cnt[boost_chan_q] <= '0;
        end
      end else if (mode_i == 2'b00) begin
        order_q    <= fixed_order_i;
        period_cnt <= '0;
      end else if (mode_i == 2'b10 && starve_hit) begin
        state        <= BOOST;
        order_q      <= starve_sel;
        boost_chan_q <= starve_sel;
        boost_q      <= 1'b1;
        period_cnt   <= '0;
      end else if (period_i == '0) begin
        period_cnt <= '0;
      end else if (period_cnt == period_i - PERIOD_W'(1)) begin
        order_q    <= order_q + CW'(1);
        period_cnt <= '0;
      end else begin
        period_cnt <= period_cnt + PERIOD_W'(1);
      end
    end
  end

  assign sched.order      = order_q;
  assign sched.boost      = boost_q;
  assign sched.boost_chan = boost_chan_q;

endmodule

// File: tb/tb_hwpe_stream_tcdm_order_sched.sv
// Directed checks of the order scheduler: table of per-cycle vectors plus
// hand-written adaptive boost, saturation and enable-drop sequences.
module tb_hwpe_stream_tcdm_order_sched;

  logic       clk = 1'b0;
  logic       rst, clr, en;
  logic [1:0] mode, fix;
  logic [7:0] per;
  logic [5:0] thr;

  int errors = 0;
  int checks = 0;

  hwpe_stream_tcdm_order_sched_if #(.NB_CHAN(4)) sif ();

  hwpe_stream_tcdm_order_sched #(
    .NB_CHAN (4),
    .PERIOD_W(8),
    .STARVE_W(6)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (clr),
    .enable_i     (en),
    .mode_i       (mode),
    .fixed_order_i(fix),
    .period_i     (per),
    .starve_thr_i (thr),
    .sched        (sif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, clr, en;
    logic [1:0] mode, fix;
    logic [7:0] per;
    logic [5:0] thr;
    logic [3:0] req, gnt;
    logic [1:0] e_order;
    logic       e_boost;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, c, e, input logic [1:0] m, f,
                              input logic [7:0] p, input logic [5:0] t,
                              input logic [3:0] rq, g, input logic [1:0] eo,
                              input logic eb);
    vec_t v;
    v.rst = r; v.clr = c; v.en = e; v.mode = m; v.fix = f; v.per = p; v.thr = t;
    v.req = rq; v.gnt = g; v.e_order = eo; v.e_boost = eb;
    return v;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] p,
                       input logic [5:0] t, input logic [3:0] rq, g);
    rst = 1'b0; clr = 1'b0; en = e; mode = m; per = p; thr = t;
    sif.in_req = rq; sif.in_gnt = g;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; en = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
  endtask

  initial begin
    logic [1:0] seq [13] = '{0,0,0,1,1,1,2,2,2,3,3,3,0};
    rst = 1'b1; clr = 1'b0; en = 1'b0; mode = 2'b00; fix = 2'b00;
    per = '0; thr = '0; sif.in_req = '0; sif.in_gnt = '0;

    // reset with busy inputs
    tbl.push_back(mk(1,0,1,2'b10,2'd3,8'd1,6'd1,4'hF,4'h0,2'd0,1'b0));
    tbl.push_back(mk(1,0,1,2'b01,2'd2,8'd2,6'd1,4'hA,4'h5,2'd0,1'b0));
    // periodic, period 3, first edge is IDLE->RUN
    for (int i = 0; i < 13; i++)
      tbl.push_back(mk(0,0,1,2'b01,2'd0,8'd3,6'd0,4'h0,4'h0,seq[i],1'b0));
    tbl.push_back(mk(0,0,1,2'b01,2'd0,8'd3,6'd0,4'h0,4'h0,2'd0,1'b0));
    tbl.push_back(mk(0,0,1,2'b01,2'd0,8'd3,6'd0,4'h0,4'h0,2'd0,1'b0));
    tbl.push_back(mk(0,0,1,2'b01,2'd0,8'd3,6'd0,4'h0,4'h0,2'd1,1'b0));
    // clear mid-RUN with enable still high
    tbl.push_back(mk(0,1,1,2'b01,2'd0,8'd3,6'd0,4'h0,4'h0,2'd0,1'b0));
    tbl.push_back(mk(0,0,1,2'b01,2'd0,8'd3,6'd0,4'h0,4'h0,2'd0,1'b0));
    // fixed mode, starving channels must not boost
    tbl.push_back(mk(0,0,1,2'b00,2'd2,8'd3,6'd1,4'h0,4'h0,2'd2,1'b0));
    tbl.push_back(mk(0,0,1,2'b00,2'd2,8'd3,6'd1,4'h0,4'h0,2'd2,1'b0));
    tbl.push_back(mk(0,0,1,2'b00,2'd1,8'd3,6'd1,4'h0,4'h0,2'd1,1'b0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,1,2'b00,2'd1,8'd3,6'd1,4'hF,4'h0,2'd1,1'b0));
    // enable drop holds order
    tbl.push_back(mk(0,0,0,2'b01,2'd3,8'd1,6'd1,4'hF,4'h0,2'd1,1'b0));
    tbl.push_back(mk(0,0,0,2'b01,2'd3,8'd1,6'd1,4'hF,4'h0,2'd1,1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; clr = tbl[i].clr; en = tbl[i].en; mode = tbl[i].mode;
      fix = tbl[i].fix; per = tbl[i].per; thr = tbl[i].thr;
      sif.in_req = tbl[i].req; sif.in_gnt = tbl[i].gnt;
      tick();
      check($sformatf("vec%0d.order", i), int'(sif.order), int'(tbl[i].e_order));
      check($sformatf("vec%0d.boost", i), int'(sif.boost), int'(tbl[i].e_boost));
    end

    // period 0 never rotates
    do_reset();
    drive(1, 2'b01, 8'd0, 6'd0, 4'h0, 4'h0);
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("per0.order%0d", k), int'(sif.order), 0);
    end

    // adaptive single channel: thr 4, boost visible 5 cycles after starvation starts
    do_reset();
    drive(1, 2'b10, 8'd0, 6'd4, 4'h0, 4'h0);
    tick();
    sif.in_req = 4'b0100;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("single.boost%0d", k), int'(sif.boost), (k >= 5) ? 1 : 0);
      check($sformatf("single.order%0d", k), int'(sif.order), (k >= 5) ? 2 : 0);
    end
    check("single.chan", int'(sif.boost_chan), 2);
    sif.in_gnt = 4'b0100;
    tick();
    check("single.exit_boost", int'(sif.boost), 0);
    check("single.exit_order", int'(sif.order), 2);

    // tie between ch1 and ch3, then ch3 saturated past the 6-bit wrap point
    do_reset();
    drive(1, 2'b10, 8'd0, 6'd4, 4'h0, 4'h0);
    tick();
    sif.in_req = 4'b1010;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 4)  check("tie.boost4", int'(sif.boost), 0);
      if (k == 5) begin
        check("tie.boost5", int'(sif.boost), 1);
        check("tie.chan5", int'(sif.boost_chan), 1);
        check("tie.order5", int'(sif.order), 1);
      end
      if (k == 64) check("tie.hold64", int'(sif.boost_chan), 1);
    end
    sif.in_gnt = 4'b0010;
    tick();
    check("tie.exit_boost", int'(sif.boost), 0);
    check("tie.exit_order", int'(sif.order), 1);
    sif.in_gnt = 4'b0000;
    tick();
    check("sat.boost", int'(sif.boost), 1);
    check("sat.chan", int'(sif.boost_chan), 3);
    check("sat.order", int'(sif.order), 3);

    // enable drop in BOOST, then counters restart from zero
    en = 1'b0;
    tick();
    check("edrop.boost", int'(sif.boost), 0);
    check("edrop.order", int'(sif.order), 3);
    tick();
    check("idle.order", int'(sif.order), 3);
    en = 1'b1;
    tick();
    check("reen.boost", int'(sif.boost), 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("reen.boost%0d", k), int'(sif.boost), (k >= 5) ? 1 : 0);
    end
    check("reen.chan", int'(sif.boost_chan), 1);
    check("reen.order", int'(sif.order), 1);

    // leaving adaptive mode ends the boost
    mode = 2'b01;
    tick();
    check("modex.boost", int'(sif.boost), 0);
    check("modex.order", int'(sif.order), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
